// File: rtl/mul_pool.sv
// mul_pool: shared pool of GNTS_N pipelined signed fractional multipliers.
// Sits directly behind the multi-grant round-robin multiplier arbiter. A rising
// grant on a port is a start event. The port's operands are steered to the unit
// the arbiter assigned, and the saturated Q1.(DATA_W-1) product returns to that
// port three cycles later, together with a one-cycle done pulse.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high; flushes the pipeline
//   a_in/b_in  - per-port operands, port p at [p*DATA_W +: DATA_W]
//   gnt_in     - arbiter grants, one bit per port
//   gnt_id_in  - arbiter unit assignment, port p at [p*GNTS_W +: GNTS_W]
//   res_out    - per-port result, holds between done pulses
//   done_out   - one-cycle pulse per completed operation
//   err_out    - sticky protocol-error flag, cleared only by reset
module mul_pool #(
  parameter int PORTS_N = 4,
  parameter int GNTS_N  = 2,
  parameter int GNTS_W  = 1,
  parameter int DATA_W  = 18
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PORTS_N*DATA_W-1:0]   a_in,
  input  logic [PORTS_N*DATA_W-1:0]   b_in,
  input  logic [PORTS_N-1:0]          gnt_in,
  input  logic [PORTS_N*GNTS_W-1:0]   gnt_id_in,
  output logic [PORTS_N*DATA_W-1:0]   res_out,
  output logic [PORTS_N-1:0]          done_out,
  output logic                        err_out
);

  localparam int TAG_W  = (PORTS_N > 1) ? $clog2(PORTS_N) : 1;
  localparam int PROD_W = 2 * DATA_W;

  logic [PORTS_N-1:0]              gnt_prev_q, gnt_prev_d;
  logic [PORTS_N-1:0]              start;

  // Stage 1: issue registers
  logic signed [DATA_W-1:0]        op_a_q [GNTS_N];
  logic signed [DATA_W-1:0]        op_a_d [GNTS_N];
  logic signed [DATA_W-1:0]        op_b_q [GNTS_N];
  logic signed [DATA_W-1:0]        op_b_d [GNTS_N];
  logic [TAG_W-1:0]                tag_q  [GNTS_N];
  logic [TAG_W-1:0]                tag_d  [GNTS_N];
  logic [GNTS_N-1:0]               v1_q, v1_d;

  // Stage 2: multiply registers
  logic signed [PROD_W-1:0]        prod_q [GNTS_N];
  logic signed [PROD_W-1:0]        prod_d [GNTS_N];
  logic [TAG_W-1:0]                tag2_q [GNTS_N];
  logic [GNTS_N-1:0]               v2_q, v2_d;

  // Stage 3: per-port return registers
  logic [PORTS_N*DATA_W-1:0]       res_q, res_d;
  logic [PORTS_N-1:0]              done_q, done_d;
  logic                            err_q, err_d;

  // Only (-1)*(-1) overflows: it is the one product whose top two bits differ.
  function automatic logic [DATA_W-1:0] format_prod(input logic signed [PROD_W-1:0] p);
    if (p[PROD_W-1] != p[PROD_W-2]) begin
      format_prod = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      format_prod = p[PROD_W-2 -: DATA_W];
    end
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    gnt_prev_d = gnt_in;
    start      = gnt_in & ~gnt_prev_q;
    v1_d       = '0;
    err_d      = err_q;
    res_d      = res_q;
    done_d     = '0;
    for (int u = 0; u < GNTS_N; u++) begin
      op_a_d[u] = op_a_q[u];
      op_b_d[u] = op_b_q[u];
      tag_d[u]  = tag_q[u];
      prod_d[u] = PROD_W'(op_a_q[u]) * PROD_W'(op_b_q[u]);
    end
    v2_d = v1_q;

    // Issue: ascending port order, so the lowest port claims a contested unit.
    for (int p = 0; p < PORTS_N; p++) begin
      if (start[p]) begin
        if (int'(gnt_id_in[p*GNTS_W +: GNTS_W]) >= GNTS_N) begin
          err_d = 1'b1;
        end else begin
          for (int u = 0; u < GNTS_N; u++) begin
            if (int'(gnt_id_in[p*GNTS_W +: GNTS_W]) == u) begin
              if (v1_d[u]) begin
                err_d = 1'b1;
              end else begin
                v1_d[u]   = 1'b1;
                op_a_d[u] = a_in[p*DATA_W +: DATA_W];
                op_b_d[u] = b_in[p*DATA_W +: DATA_W];
                tag_d[u]  = TAG_W'(p);
              end
            end
          end
        end
      end
    end

    // Return: descending unit order, so the lower unit writes last and wins.
    for (int u = GNTS_N - 1; u >= 0; u--) begin
      if (v2_q[u]) begin
        if (done_d[tag2_q[u]]) err_d = 1'b1;
        res_d[int'(tag2_q[u])*DATA_W +: DATA_W] = format_prod(prod_q[u]);
        done_d[tag2_q[u]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops take non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      gnt_prev_q <= '0;
      v1_q       <= '0;
      v2_q       <= '0;
      res_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      // NOTE: operand, tag and product registers are cleared too so the datapath
      // never exposes pre-reset data; they are small flop arrays, not memories.
      for (int u = 0; u < GNTS_N; u++) begin
        op_a_q[u] <= '0;
        op_b_q[u] <= '0;
        tag_q[u]  <= '0;
        prod_q[u] <= '0;
        tag2_q[u] <= '0;
      end
    end else begin
      gnt_prev_q <= gnt_prev_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      res_q      <= res_d;
      done_q     <= done_d;
      err_q      <= err_d;
      for (int u = 0; u < GNTS_N; u++) begin
        op_a_q[u] <= op_a_d[u];
        op_b_q[u] <= op_b_d[u];
        tag_q[u]  <= tag_d[u];
        prod_q[u] <= prod_d[u];
        tag2_q[u] <= tag_q[u];
      end
    end
  end

  assign res_out  = res_q;
  assign done_out = done_q;
  assign err_out  = err_q;

endmodule
